// File: rtl/alu_6502_seq.sv
// Sequential 6502-style ALU: one-cycle binary ops, nibble-serial BCD ADC/SBC,
// valid/ready handshake on request and result sides.
module alu_6502_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          DEC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             d_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);
  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_BIT = 4'd12;

  typedef enum logic [1:0] {IDLE = 2'd0, ADJ = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx, y_nx;
  logic             sub_q, sub_nx, cy_q, cy_nx;
  logic [KW-1:0]    k_q, k_nx;
  logic             c_nx, z_nx, n_nx, v_nx;

  logic [WIDTH:0]   bin_sum;
  logic [WIDTH-1:0] bin_b, bin_y;
  logic             bin_c, bin_n, bin_v;

  logic [3:0]       an, bn, dig;
  logic [4:0]       s;
  logic             dcy;
  logic [WIDTH-1:0] dec_y;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // Binary result computed directly from the request so it registers at accept
  always_comb begin
    bin_b   = (op == OP_SBC) ? ~b : b;
    bin_sum = '0;
    bin_y   = '0;
    bin_c   = 1'b0;
    bin_v   = 1'b0;
    case (op)
      OP_ADC, OP_SBC: begin
        bin_sum = {1'b0, a} + {1'b0, bin_b} + {{WIDTH{1'b0}}, c_in};
        bin_y   = bin_sum[MSB:0];
        bin_c   = bin_sum[WIDTH];
        bin_v   = (a[MSB] == bin_b[MSB]) && (bin_y[MSB] != a[MSB]);
      end
      OP_CMP: begin
        bin_y = a - b;
        bin_c = (a >= b);
      end
      OP_AND: bin_y = a & b;
      OP_ORA: bin_y = a | b;
      OP_EOR: bin_y = a ^ b;
      OP_ASL: begin bin_y = {a[MSB-1:0], 1'b0}; bin_c = a[MSB]; end
      OP_LSR: begin bin_y = {1'b0, a[MSB:1]};   bin_c = a[0];   end
      OP_ROL: begin bin_y = {a[MSB-1:0], c_in}; bin_c = a[MSB]; end
      OP_ROR: begin bin_y = {c_in, a[MSB:1]};   bin_c = a[0];   end
      OP_INC: bin_y = a + ONE;
      OP_DEC: bin_y = a - ONE;
      OP_BIT: begin bin_y = a & b; bin_v = b[MSB-1]; end
      default: bin_y = '0;
    endcase
    bin_n = (op == OP_BIT) ? b[MSB] : bin_y[MSB];
  end

  // One BCD digit step; cy_q holds the carry (ADC) or the borrow (SBC)
  always_comb begin
    an  = 4'(a_q >> {k_q, 2'b00});
    bn  = 4'(b_q >> {k_q, 2'b00});
    dcy = 1'b0;
    if (sub_q) begin
      s = {1'b0, an} - {1'b0, bn} - {4'b0000, cy_q};
      if (s[4]) begin
        s   = s + 5'd10;
        dcy = 1'b1;
      end
    end else begin
      s = {1'b0, an} + {1'b0, bn} + {4'b0000, cy_q};
      if (s > 5'd9) begin
        s   = s + 5'd6;
        dcy = 1'b1;
      end
    end
    dig   = s[3:0];
    dec_y = y;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (k_q == KW'(i)) dec_y[i*4 +: 4] = dig;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    sub_nx   = sub_q;
    cy_nx    = cy_q;
    k_nx     = k_q;
    y_nx     = y;
    c_nx     = c;
    z_nx     = z;
    n_nx     = n;
    v_nx     = v;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (DEC_EN && d_mode && ((op == OP_ADC) || (op == OP_SBC))) begin
            state_nx = ADJ;
            a_nx     = a;
            b_nx     = b;
            sub_nx   = (op == OP_SBC);
            cy_nx    = (op == OP_SBC) ? ~c_in : c_in;
            k_nx     = '0;
            y_nx     = '0;
            c_nx     = 1'b0;
            z_nx     = 1'b0;
            n_nx     = 1'b0;
            v_nx     = 1'b0;
          end else begin
            state_nx = DONE;
            y_nx     = bin_y;
            c_nx     = bin_c;
            z_nx     = (bin_y == '0);
            n_nx     = bin_n;
            v_nx     = bin_v;
          end
        end
      end
      ADJ: begin
        y_nx  = dec_y;
        cy_nx = dcy;
        k_nx  = k_q + KW'(1);
        if (k_q == KW'(NIB - 1)) begin
          state_nx = DONE;
          c_nx     = sub_q ? ~dcy : dcy;
          z_nx     = (dec_y == '0);
          n_nx     = dec_y[MSB];
          v_nx     = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      cy_q  <= 1'b0;
      k_q   <= '0;
      y     <= '0;
      c     <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
      v     <= 1'b0;
    end else begin
      state <= state_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      sub_q <= sub_nx;
      cy_q  <= cy_nx;
      k_q   <= k_nx;
      y     <= y_nx;
      c     <= c_nx;
      z     <= z_nx;
      n     <= n_nx;
      v     <= v_nx;
    end
  end
endmodule

// File: tb/tb_alu_6502_seq.sv
// Directed bench for alu_6502_seq: scoreboard of expected results per request,
// plus DEC_EN=0 and WIDTH=16 instances for the parameter-dependent cases.
module tb_alu_6502_seq;
  localparam logic [3:0] ADC = 4'd0, SBC = 4'd1, AND_ = 4'd2, ORA = 4'd3, EOR = 4'd4,
                         ASL = 4'd5, LSR = 4'd6, ROL = 4'd7, ROR = 4'd8, CMP = 4'd9,
                         INC = 4'd10, DEC = 4'd11, BIT_ = 4'd12, BAD = 4'd13;

  typedef struct {
    string      tag;
    logic [7:0] y;
    logic [3:0] f;   // {c,z,n,v}
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, c_in, d_mode;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       in_ready, out_valid, c, z, n, v;
  logic [7:0] y;

  logic       in_ready_nd, out_valid_nd, c_nd, z_nd, n_nd, v_nd;
  logic [7:0] y_nd;

  logic        in_valid16, c_in16, d_mode16, in_ready16, out_valid16, c16, z16, n16, v16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, y16;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] snap_nd_y;
  logic       snap_nd_c, snap_nd_ov;

  always #5 clk = ~clk;

  alu_6502_seq #(.WIDTH(8), .DEC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .c_in(c_in), .d_mode(d_mode), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .c(c), .z(z), .n(n), .v(v));

  alu_6502_seq #(.WIDTH(8), .DEC_EN(1'b0)) dut_nd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nd), .op(op),
    .a(a), .b(b), .c_in(c_in), .d_mode(d_mode), .out_valid(out_valid_nd),
    .out_ready(1'b1), .y(y_nd), .c(c_nd), .z(z_nd), .n(n_nd), .v(v_nd));

  alu_6502_seq #(.WIDTH(16), .DEC_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .c_in(c_in16), .d_mode(d_mode16), .out_valid(out_valid16),
    .out_ready(1'b1), .y(y16), .c(c16), .z(z16), .n(n16), .v(v16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expectation and compare it with the result now on the outputs
  task automatic collect(input int cnt);
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ":lat"}, 32'(cnt), 32'(e.lat));
    chk({e.tag, ":ov"}, 32'(out_valid), 32'(1));
    chk({e.tag, ":y"}, 32'(y), 32'(e.y));
    chk({e.tag, ":czvn"}, 32'({c, z, n, v}), 32'(e.f));
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [7:0] ia,
                     input logic [7:0] ib, input logic ci, input logic di,
                     input logic [7:0] ey, input logic [3:0] ef, input int elat);
    exp_t e;
    int   cnt;
    e.tag = tag; e.y = ey; e.f = ef; e.lat = elat;
    sb.push_back(e);
    op = o; a = ia; b = ib; c_in = ci; d_mode = di; in_valid = 1'b1;
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    snap_nd_y = y_nd; snap_nd_c = c_nd; snap_nd_ov = out_valid_nd;
    cnt = 1;
    while (!out_valid && cnt < 32) begin
      @(posedge clk); #1;
      cnt++;
    end
    collect(cnt);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ci, input logic [15:0] ey, input logic ec);
    int cnt;
    op16 = ADC; a16 = ia; b16 = ib; c_in16 = ci; d_mode16 = 1'b1; in_valid16 = 1'b1;
    chk({tag, ":in_ready"}, 32'(in_ready16), 32'(1));
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    cnt = 1;
    while (!out_valid16 && cnt < 32) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ":lat"}, 32'(cnt), 32'(5));
    chk({tag, ":y"}, 32'(y16), 32'(ey));
    chk({tag, ":c"}, 32'(c16), 32'(ec));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = ADC; a = '0; b = '0;
    c_in = 1'b0; d_mode = 1'b0;
    in_valid16 = 1'b0; op16 = ADC; a16 = '0; b16 = '0; c_in16 = 1'b0; d_mode16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:ov", 32'(out_valid), 32'(0));
    chk("rst:y", 32'(y), 32'(0));
    chk("rst:czvn", 32'({c, z, n, v}), 32'(0));
    chk("rst:in_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    #1;

    // op, a, b, c_in, d, y, {c,z,n,v}, latency
    run("adc_bin", ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b0011, 1);
    run("adc_dec", ADC, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 4'b1000, 3);
    chk("nd_adc:ov", 32'(snap_nd_ov), 32'(1));
    chk("nd_adc:y", 32'(snap_nd_y), 32'(8'h9F));
    chk("nd_adc:c", 32'(snap_nd_c), 32'(0));
    run("sbc_dec", SBC, 8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 4'b0010, 3);
    run("sbc_bin", SBC, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 4'b0011, 1);
    run("cmp_eq", CMP, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00, 4'b1100, 1);
    run("cmp_lt", CMP, 8'h30, 8'h40, 1'b1, 1'b0, 8'hF0, 4'b0010, 1);
    run("ror", ROR, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1010, 1);
    run("rol", ROL, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1100, 1);
    run("asl", ASL, 8'hC1, 8'h00, 1'b0, 1'b0, 8'h82, 4'b1010, 1);
    run("lsr", LSR, 8'h03, 8'h00, 1'b0, 1'b0, 8'h01, 4'b1000, 1);
    run("bit", BIT_, 8'h0F, 8'hC0, 1'b0, 1'b0, 8'h00, 4'b0111, 1);
    run("and_d", AND_, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 4'b0000, 1);
    run("ora", ORA, 8'h0F, 8'h30, 1'b0, 1'b0, 8'h3F, 4'b0000, 1);
    run("eor", EOR, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 4'b0010, 1);
    run("inc", INC, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0100, 1);
    run("dec", DEC, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b0010, 1);
    run("bad", BAD, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 4'b0100, 1);

    // Result held while the consumer stalls; requests meanwhile are dropped
    out_ready = 1'b0;
    run("hold", ADC, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0011, 1);
    op = EOR; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold:ov", 32'(out_valid), 32'(1));
      chk("hold:y", 32'(y), 32'(8'h80));
      chk("hold:czvn", 32'({c, z, n, v}), 32'(4'b0011));
      chk("hold:in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release:in_ready", 32'(in_ready), 32'(1));
    chk("release:ov", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("dropped:ov", 32'(out_valid), 32'(0));

    // Reset while a decimal op is mid-adjust
    op = ADC; a = 8'h58; b = 8'h46; c_in = 1'b1; d_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_adj:ov", 32'(out_valid), 32'(0));
    chk("rst_adj:y", 32'(y), 32'(0));
    chk("rst_adj:czvn", 32'({c, z, n, v}), 32'(0));
    chk("rst_adj:in_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst:ov", 32'(out_valid), 32'(0));
    run("adc_ff", ADC, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1100, 1);

    run16("w16_9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run16("w16_1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
